// File: rtl/fetch_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_ctrl_if
// Instruction-memory bus used by the fetch stage.
//   Request channel (valid/ready): imem_req_valid, imem_req_ready,
//                                  imem_req_addr (byte address, [1:0]=0)
//   Response channel (valid only): imem_rsp_valid, imem_rsp_data
//                                  (in request order, never back-pressured)
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_stage_ctrl_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_stage_ctrl
// Instruction-fetch front end of a 5-stage RV32 pipeline. Issues in-order
// requests to instruction memory, buffers returned words with their PC in a
// small FIFO and presents the head to Decode. A flush redirects the PC and
// discards every response still in flight for requests issued before it.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   stall_D       Decode hold: do not pop the FIFO
//   flush         redirect to pc_target_E (overrides stall_D)
//   pc_target_E   redirect target, bits [1:0] ignored
//   imem          instruction-memory bus (master side)
//   valid_D       instr_D/pc_D/pcplus4_D hold a valid instruction
//   instr_D, pc_D, pcplus4_D  FIFO head (all zero when empty)
//
// Optional feature (define FETCH_PERF_CNT_EN):
//   perf_fetched  responses pushed into the FIFO (wraps at 2^32)
//   perf_dropped  responses discarded after a flush (wraps at 2^32)
// ---------------------------------------------------------------------------
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_D,
  input  logic                      flush,
  input  logic [31:0]               pc_target_E,
  fetch_stage_ctrl_if.master        imem,
  output logic                      valid_D,
  output logic [31:0]               instr_D,
  output logic [31:0]               pc_D,
  output logic [31:0]               pcplus4_D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_dropped
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [AW:0] ptr_t;

  logic [31:0]      pc_fetch_q, pc_fetch_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  logic [31:0] fifo_pc_q    [FIFO_DEPTH];
  logic [31:0] pcq_q        [FIFO_DEPTH];   // PCs of live (non-dropped) requests
  ptr_t        fifo_wr_q, fifo_rd_q;
  ptr_t        pcq_wr_q,  pcq_rd_q;

  ptr_t        fifo_count;
  logic [31:0] credit_used;
  logic        accept, rsp_drop, push, pop;
  logic [31:0] head_pc;

  // Credits cover everything in flight (including responses that will be
  // dropped) plus everything buffered, so the FIFO can never overflow.
  assign fifo_count  = fifo_wr_q - fifo_rd_q;
  assign credit_used = 32'(outstanding_q) + 32'(fifo_count);

  assign imem.imem_req_valid = !rst && !flush && (credit_used < 32'(FIFO_DEPTH));
  assign imem.imem_req_addr  = pc_fetch_q;

  assign accept   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_drop = imem.imem_rsp_valid && (flush || (drop_cnt_q != '0));
  assign push     = imem.imem_rsp_valid && !rsp_drop;

  assign valid_D   = (fifo_count != '0);
  assign pop       = valid_D && !stall_D && !flush;
  assign head_pc   = fifo_pc_q[fifo_rd_q[AW-1:0]];
  assign instr_D   = valid_D ? fifo_instr_q[fifo_rd_q[AW-1:0]] : 32'h0;
  assign pc_D      = valid_D ? head_pc : 32'h0;
  assign pcplus4_D = valid_D ? head_pc + 32'd4 : 32'h0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem.imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    pc_fetch_d    = pc_fetch_q;

    if (flush) begin
      // No request is accepted in a flush cycle, so whatever stays in flight
      // after this edge belongs to the wrong path.
      drop_cnt_d = outstanding_q - CNT_W'(imem.imem_rsp_valid);
      pc_fetch_d = {pc_target_E[31:2], 2'b00};
    end else begin
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (accept)   pc_fetch_d = pc_fetch_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      pc_fetch_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
    end else begin
      pc_fetch_q    <= pc_fetch_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      if (flush) begin
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
        pcq_wr_q  <= '0;
        pcq_rd_q  <= '0;
      end else begin
        if (accept) pcq_wr_q <= pcq_wr_q + ptr_t'(1);
        if (push) begin
          fifo_wr_q <= fifo_wr_q + ptr_t'(1);
          pcq_rd_q  <= pcq_rd_q + ptr_t'(1);
        end
        if (pop) fifo_rd_q <= fifo_rd_q + ptr_t'(1);
      end
    end
  end

  // NOTE: storage arrays are not reset; the pointers alone define valid content.
  always_ff @(posedge clk) begin
    if (accept) pcq_q[pcq_wr_q[AW-1:0]] <= pc_fetch_q;
    if (push) begin
      fifo_instr_q[fifo_wr_q[AW-1:0]] <= imem.imem_rsp_data;
      fifo_pc_q[fifo_wr_q[AW-1:0]]    <= pcq_q[pcq_rd_q[AW-1:0]];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_dropped <= 32'h0;
    end else begin
      if (push)     perf_fetched <= perf_fetched + 32'd1;
      if (rsp_drop) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule
